// File: rtl/iir_biquad_secuencial.sv
// Biquad IIR section: one sample in, one sample out, single shared multiplier.
// Ports: clk, reset, banda_sel, x_in/x_valid, coef_*, sel, y_out/y_valid, busy, overrun.
module iir_biquad_secuencial #(
  parameter int width = 22,
  parameter int frac  = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       banda_sel,
  input  logic [width-1:0] x_in,
  input  logic             x_valid,
  input  logic [width-1:0] coef_b0,
  input  logic [width-1:0] coef_b1,
  input  logic [width-1:0] coef_b2,
  input  logic [width-1:0] coef_a1,
  input  logic [width-1:0] coef_a2,
  output logic [1:0]       sel,
  output logic [width-1:0] y_out,
  output logic             y_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int aw = 2*width+3;

  localparam logic signed [aw-1:0] half =
    aw'(1) << (frac-1);
  localparam logic signed [aw-1:0] maxv =
    {{(aw-width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [aw-1:0] minv =
    {{(aw-width+1){1'b1}}, {(width-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, LOAD, MAC_B0, MAC_B1,
    MAC_B2, MAC_A1, MAC_A2, SAT
  } state_t;

  state_t state;

  logic signed [width-1:0] x0, x1, x2;
  logic signed [width-1:0] y1, y2;
  logic signed [aw-1:0]    acc;
  logic                    chg;

  logic signed [width-1:0]   m_coef;
  logic signed [width-1:0]   m_opnd;
  logic signed [2*width-1:0] prod;
  logic signed [aw-1:0]      prod_ext;
  logic signed [aw-1:0]      rnd;
  logic signed [aw-1:0]      r;
  logic signed [width-1:0]   s;

  // Operand steering for the shared multiplier.
  always_comb begin
    m_coef = '0;
    m_opnd = '0;
    unique case (state)
      MAC_B0: begin
        m_coef = coef_b0;
        m_opnd = x0;
      end
      MAC_B1: begin
        m_coef = coef_b1;
        m_opnd = x1;
      end
      MAC_B2: begin
        m_coef = coef_b2;
        m_opnd = x2;
      end
      MAC_A1: begin
        m_coef = coef_a1;
        m_opnd = y1;
      end
      MAC_A2: begin
        m_coef = coef_a2;
        m_opnd = y2;
      end
      default: begin
        m_coef = '0;
        m_opnd = '0;
      end
    endcase
  end

  assign prod     = m_coef * m_opnd;
  assign prod_ext = {{(aw-2*width){prod[2*width-1]}}, prod};

  // Round half up, back to Q.0, then clamp.
  always_comb begin
    rnd = acc + half;
    r   = rnd >>> frac;
    if (r > maxv) begin
      s = maxv[width-1:0];
    end else if (r < minv) begin
      s = minv[width-1:0];
    end else begin
      s = r[width-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= 2'b00;
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      y1      <= '0;
      y2      <= '0;
      acc     <= '0;
      chg     <= 1'b0;
      y_out   <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (x_valid && state != IDLE) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (x_valid) begin
            x0    <= x_in;
            sel   <= banda_sel;
            chg   <= (banda_sel != sel);
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          acc <= '0;
          // New band: drop history from the old filter.
          if (chg) begin
            x1 <= '0;
            x2 <= '0;
            y1 <= '0;
            y2 <= '0;
          end
          state <= MAC_B0;
        end
        MAC_B0: begin
          acc   <= acc + prod_ext;
          state <= MAC_B1;
        end
        MAC_B1: begin
          acc   <= acc + prod_ext;
          state <= MAC_B2;
        end
        MAC_B2: begin
          acc   <= acc + prod_ext;
          state <= MAC_A1;
        end
        MAC_A1: begin
          acc   <= acc - prod_ext;
          state <= MAC_A2;
        end
        MAC_A2: begin
          acc   <= acc - prod_ext;
          state <= SAT;
        end
        SAT: begin
          y_out   <= s;
          y_valid <= 1'b1;
          x2      <= x1;
          x1      <= x0;
          y2      <= y1;
          y1      <= s;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_secuencial.sv
// Bench for iir_biquad_secuencial: directed samples, per-cycle model compare.
// Ports driven: clk, reset, banda_sel, x_in, x_valid, coef_* from band tables.
module tb_iir_biquad_secuencial;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  banda_sel;
  logic [21:0] x_in;
  logic        x_valid;
  logic [21:0] coef_b0, coef_b1, coef_b2;
  logic [21:0] coef_a1, coef_a2;
  logic [1:0]  sel;
  logic [21:0] y_out;
  logic        y_valid, busy, overrun;

  logic [21:0] tb0[4], tb1[4], tb2[4];
  logic [21:0] ta1[4], ta2[4];

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  assign coef_b0 = tb0[sel];
  assign coef_b1 = tb1[sel];
  assign coef_b2 = tb2[sel];
  assign coef_a1 = ta1[sel];
  assign coef_a2 = ta2[sel];

  iir_biquad_secuencial dut (
    .clk      (clk),
    .reset    (reset),
    .banda_sel(banda_sel),
    .x_in     (x_in),
    .x_valid  (x_valid),
    .coef_b0  (coef_b0),
    .coef_b1  (coef_b1),
    .coef_b2  (coef_b2),
    .coef_a1  (coef_a1),
    .coef_a2  (coef_a2),
    .sel      (sel),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  function automatic longint sx(input logic [21:0] v);
    return longint'($signed(v));
  endfunction

  task automatic check(input string nm,
                       input longint act,
                       input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  // Reference model: sample-level biquad plus a busy countdown.
  int      m_cnt;
  logic [1:0] m_sel;
  longint  m_x0, mx1, mx2, my1, my2;
  longint  m_pend, m_y;
  bit      m_yv, m_ovr;

  function automatic longint filt(input longint acc);
    longint r;
    r = (acc + 64'sd8192) >>> 14;
    if (r > 2097151) r = 2097151;
    if (r < -2097152) r = -2097152;
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0;
      m_sel = 2'b00;
      m_y = 0;
      m_yv = 0;
      m_ovr = 0;
      mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    end else begin
      m_yv = 0;
      if (m_cnt > 0) begin
        if (x_valid) m_ovr = 1;
        m_cnt--;
        if (m_cnt == 0) begin
          m_y = m_pend;
          m_yv = 1;
          mx2 = mx1; mx1 = m_x0;
          my2 = my1; my1 = m_pend;
        end
      end else if (x_valid) begin
        if (banda_sel != m_sel) begin
          mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        end
        m_sel = banda_sel;
        m_x0 = sx(x_in);
        m_pend = filt(sx(tb0[m_sel]) * m_x0
                    + sx(tb1[m_sel]) * mx1
                    + sx(tb2[m_sel]) * mx2
                    - sx(ta1[m_sel]) * my1
                    - sx(ta2[m_sel]) * my2);
        m_cnt = 7;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("y_valid", longint'(y_valid), longint'(m_yv));
      check("y_out", sx(y_out), m_y);
      check("busy", longint'(busy), longint'(m_cnt > 0));
      check("sel", longint'(sel), longint'(m_sel));
      check("overrun", longint'(overrun), longint'(m_ovr));
    end
  end

  task automatic set_band(input int b,
                          input longint b0, input longint b1,
                          input longint a1);
    tb0[b] = 22'(b0);
    tb1[b] = 22'(b1);
    tb2[b] = '0;
    ta1[b] = 22'(a1);
    ta2[b] = '0;
  endtask

  // Call at a negedge; returns at the negedge where y_valid is seen.
  task automatic send(input logic [21:0] x, input logic [1:0] b,
                      input int ovr_at, input bit tog,
                      output longint y);
    int lat;
    x_in = x;
    banda_sel = b;
    x_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      x_valid = (lat == ovr_at);
      if (tog) banda_sel = ~banda_sel;
    end while (!y_valid && lat < 20);
    x_valid = 1'b0;
    check("latency", longint'(lat), 8);
    y = sx(y_out);
  endtask

  initial begin
    longint y;
    int seen;
    for (int i = 0; i < 4; i++) set_band(i, 0, 0, 0);
    reset = 1'b1;
    banda_sel = 2'b00;
    x_in = '0;
    x_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_sel", longint'(sel), 0);
    check("rst_y", sx(y_out), 0);
    check("rst_yv", longint'(y_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_ovr", longint'(overrun), 0);
    reset = 1'b0;
    @(negedge clk);

    set_band(1, 16384, 0, 0);
    send(22'd16384, 2'd1, 0, 0, y);
    check("imp_1", y, 16384);
    send(22'd0, 2'd1, 0, 0, y);
    check("imp_0", y, 0);

    set_band(1, 16384, 0, -8192);
    send(22'd16384, 2'd1, 0, 0, y);
    check("rec_0", y, 16384);
    send(22'd0, 2'd1, 0, 0, y);
    check("rec_1", y, 8192);
    send(22'd0, 2'd1, 0, 0, y);
    check("rec_2", y, 4096);
    send(22'd0, 2'd1, 0, 0, y);
    check("rec_3", y, 2048);

    set_band(2, 8192, 0, 0);
    send(22'd1, 2'd2, 0, 0, y);
    check("rnd_half", y, 1);
    set_band(2, -32768, 0, 0);
    send(22'h1FFFFF, 2'd2, 0, 0, y);
    check("sat_neg", y, -2097152);
    send(22'h200000, 2'd2, 0, 0, y);
    check("sat_pos", y, 2097151);

    set_band(2, 16384, 0, 0);
    send(22'd5, 2'd2, 3, 0, y);
    check("ovr_y", y, 5);
    check("ovr_set", longint'(overrun), 1);
    send(22'd7, 2'd2, 0, 0, y);
    check("ovr_y2", y, 7);
    check("ovr_sticky", longint'(overrun), 1);

    set_band(1, 16384, 16384, -8192);
    set_band(2, 16384, 16384, 16384);
    send(22'd1000, 2'd1, 0, 0, y);
    check("band1_a", y, 1000);
    send(22'd1000, 2'd1, 0, 0, y);
    check("band1_b", y, 2500);
    check("band1_sel", longint'(sel), 1);
    send(22'd300, 2'd2, 0, 0, y);
    check("band2_clr", y, 300);
    check("band2_sel", longint'(sel), 2);
    send(22'd100, 2'd2, 0, 1, y);
    check("tog_y", y, 100);
    check("tog_sel", longint'(sel), 2);
    send(22'd12345, 2'd0, 0, 0, y);
    check("band0", y, 0);

    x_in = 22'd999;
    banda_sel = 2'd1;
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", longint'(busy), 0);
    check("abort_ovr", longint'(overrun), 0);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (y_valid) seen++;
    end
    check("abort_pulse", longint'(seen), 0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
